// File: rtl/la_bridge_if.sv
// Valid/ready array-access port between la_bridge (master) and the array test logic (slave).
interface la_bridge_if #(
    parameter int BITS   = 32,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BITS-1:0]   req_wdata;
    logic              rsp_valid;
    logic [BITS-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/la_bridge.sv
// Logic-analyzer command responder: one toggle-requested read/write per command,
// executed on the array port, with ack toggle, busy, error, count and read data returned.
module la_bridge #(
    parameter int BITS    = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [127:0]       la_data_in,
    output logic [127:0]       la_data_out,
    input  logic [127:0]       la_oen,
    la_bridge_if.master        arr
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  REQ      = 2'd1;
    localparam logic [1:0]  WAIT_RSP = 2'd2;
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

    logic [1:0]        state_r;
    logic              busy_r;
    logic              req_valid_r;
    logic              ack_r;
    logic              err_r;
    logic [15:0]       cnt_r;
    logic [15:0]       tmo_r;
    logic [BITS-1:0]   rdata_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BITS-1:0]   wdata_r;
    logic              pending_s;
    logic [127:0]      out_s;
    logic              unused_s;

    // A command is pending only while management drives the toggle bit.
    assign pending_s = (la_data_in[127] != ack_r) && !la_oen[127];
    assign unused_s  = ^{la_data_in, la_oen};

    // Command FSM; every field that leaves the block is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            req_valid_r <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= 16'd0;
            tmo_r       <= 16'd0;
            rdata_r     <= '0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pending_s) begin
                        we_r        <= la_data_in[126];
                        addr_r      <= la_data_in[96 +: ADDR_W];
                        wdata_r     <= la_data_in[0 +: BITS];
                        err_r       <= 1'b0;
                        tmo_r       <= TMO_LOAD;
                        state_r     <= REQ;
                        busy_r      <= 1'b1;
                        req_valid_r <= 1'b1;
                    end
                end
                REQ: begin
                    tmo_r <= tmo_r - 16'd1;
                    if (req_valid_r && arr.req_ready) begin
                        req_valid_r <= 1'b0;
                        if (we_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            ack_r   <= ~ack_r;
                            cnt_r   <= cnt_r + 16'd1;
                        end else begin
                            state_r <= WAIT_RSP;
                        end
                    end else if (tmo_r <= 16'd1) begin
                        req_valid_r <= 1'b0;
                        err_r       <= 1'b1;
                        rdata_r     <= '0;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        ack_r       <= ~ack_r;
                        cnt_r       <= cnt_r + 16'd1;
                    end
                end
                WAIT_RSP: begin
                    tmo_r <= tmo_r - 16'd1;
                    if (arr.rsp_valid) begin
                        rdata_r <= arr.rsp_rdata;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ack_r   <= ~ack_r;
                        cnt_r   <= cnt_r + 16'd1;
                    end else if (tmo_r <= 16'd1) begin
                        err_r   <= 1'b1;
                        rdata_r <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ack_r   <= ~ack_r;
                        cnt_r   <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Response word: unused bits stay zero, read data is zero-extended.
    always_comb begin
        out_s              = 128'd0;
        out_s[127]         = ack_r;
        out_s[126]         = busy_r;
        out_s[125]         = err_r;
        out_s[96 +: 16]    = cnt_r;
        out_s[0 +: BITS]   = rdata_r;
    end

    assign la_data_out   = out_s;
    assign arr.req_valid = req_valid_r;
    assign arr.req_we    = we_r;
    assign arr.req_addr  = addr_r;
    assign arr.req_wdata = wdata_r;

endmodule

// File: doc/la_bridge.md
# la_bridge

Logic-analyzer command responder for the toy-sram user project. The management SoC issues single read/write commands by driving LA bits and flipping a request toggle. `la_bridge` decodes each command, runs one transaction on a downstream valid/ready array-access port, and returns status, a completion count and read data on `la_data_out`. It is the slave end of the LA pins that `misc` receives, and sits between the LA bus and the array test logic.

## Interface
- `BITS`, 32, data width of the array port; must be ≤ 32.
- `ADDR_W`, 10, address width; must be ≤ 16.
- `TIMEOUT`, 255, maximum cycles spent waiting in `REQ` or `WAIT_RSP`; range 1..65535.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `la_data_in`  in  128  command from management:
  - [127] request toggle.
  - [126] write enable.
  - [111:96] address; low `ADDR_W` bits used.
  - [31:0] write data; low `BITS` bits used.
  - All other bits are ignored.
- `la_data_out`  out  128  response to management:
  - [127] ack toggle.
  - [126] busy.
  - [125] error.
  - [111:96] completion count.
  - [31:0] read data, zero-extended.
  - All other bits are 0.
- `la_oen`  in  128  LA direction. Commands are recognised only while `la_oen[127]`=0, meaning management is driving bit 127.
- `req_valid`  out  1  array request valid.
- `req_ready`  in  1  array accepts the request.
- `req_we`  out  1  write (1) or read (0).
- `req_addr`  out  `ADDR_W`  array address.
- `req_wdata`  out  `BITS`  write data.
- `rsp_valid`  in  1  read data valid. Single-cycle pulse; only expected for reads.
- `rsp_rdata`  in  `BITS`  read data.

## Operation
- **Pending condition:** a command is pending when `la_data_in[127]` ≠ ack toggle and `la_oen[127]`=0.
- **FSM states:** `IDLE`, `REQ`, `WAIT_RSP`.
- **IDLE → REQ:** taken when a command is pending.
  - Capture we, addr and wdata into registers.
  - Clear error.
  - Load the timeout counter with `TIMEOUT`.
- **REQ:**
  - `req_valid`=1; the registered fields drive `req_we`, `req_addr`, `req_wdata`.
  - On `req_valid && req_ready`:
    - Write: go to IDLE and complete.
    - Read: go to `WAIT_RSP`.
- **WAIT_RSP:**
  - On `rsp_valid`: capture `rsp_rdata` into the read-data register, go to IDLE and complete.
  - `rsp_valid` outside `WAIT_RSP` is ignored.
- **Timeout:** the counter decrements every cycle in `REQ` and `WAIT_RSP`. If it reaches 0 with no handshake:
  - Set error.
  - Zero the read-data register.
  - Go to IDLE and complete.
  - `req_valid` drops in the same transition.
- **Completion:**
  - Flip the ack toggle.
  - Increment the 16-bit completion count; it wraps from 0xFFFF to 0x0000.
- **busy:** 1 in `REQ` and `WAIT_RSP`.
- **Field stability:** management holds command fields stable until the ack toggle equals its request toggle. Changes to the fields after capture have no effect on the current command.
- **Sticky values:**
  - error stays set until the next capture.
  - Read data holds its value until the next read completes or times out. Writes do not change it.
- **Reset:**
  - State goes to IDLE.
  - Ack toggle, count, error, read data and every output go to 0.
  - A transaction in flight is abandoned without a handshake. Any late `rsp_valid` is ignored.
  - If `la_data_in[127]`=1 when reset releases, a command is pending immediately and is executed.

## Timing
- **Capture:** a command pending at clock edge 0 (IDLE) gives `req_valid`=1 in cycle 1.
- **Write latency:** with `req_ready`=1 in cycle 1, the handshake is at edge 1. Ack toggle and count update and `req_valid`=0 in cycle 2. Total latency is 2 cycles.
- **Read latency:** handshake at edge 1 and `rsp_valid` in cycle 2 give ack and rdata updated in cycle 3.
- **Ready stall:** `req_valid` and the request fields stay stable until `req_ready`.
- **Back-to-back:** a new toggle flip while IDLE is captured at the next edge. The minimum command spacing is 2 cycles for writes.
- **Timeout:** error and ack update in the cycle following the `TIMEOUT`-th wait cycle.
- **Output registers:** all `la_data_out` bits and `req_*` outputs are registered.

## Test plan
- **Write, ready=1:** reset, then a write with addr 0x005 and wdata 0xDEADBEEF, toggle 0→1. Expect:
  - `req_valid` in cycle 1 with matching fields.
  - ack=1, count=1, error=0, busy=0 in cycle 2.
- **Read, delayed response:** a read of addr 0x3FF with `req_ready` low for 3 cycles, then `rsp_valid` with data 0x12345678 two cycles after acceptance. Expect:
  - The request is held stable while stalled.
  - `la_data_out[31:0]`=0x12345678.
  - ack flips and count increments by 1.
- **Timeout:** `TIMEOUT`=4 and `req_ready` held at 0. Expect:
  - error=1 and rdata=0.
  - ack flips after 4 wait cycles and `req_valid` deasserts.
  - The next successful command clears error.
- **Gating and field changes:** flip the toggle with `la_oen[127]`=1 → no request. Clear `la_oen[127]` → the command executes. Changing addr mid-transaction does not alter `req_addr`.
- **Reset in WAIT_RSP:** assert reset while in `WAIT_RSP`. Expect all outputs 0 the next cycle, and a later `rsp_valid` ignored. If the request toggle is still 1, the command re-executes after release.
- **Count wrap:** preload 65535 completions via fast writes → count reads 0x0000 after the 65536th completion.
